// File: rtl/axi_10g_ethernet_0_tx_seg_ctrl.sv
// ============================================================================
// Module   : axi_10g_ethernet_0_tx_seg_ctrl
// Brief    : TX segment scheduler. Pops one payload checksum, issues one
//            segment descriptor, then forwards one segment of payload beats.
//            Optional per-segment counter enabled by macro SEG_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_10g_ethernet_0_tx_seg_ctrl #(
    parameter int TCP_DATA_LENGTH = 1456,
    parameter int SEQ_W           = 32
) (
    input  logic             s_aclk,
    input  logic             s_areset,
    input  logic             enable,
    input  logic             seq_load,
    input  logic [SEQ_W-1:0] init_seq,
    input  logic [SEQ_W-1:0] ack_num,
    input  logic [15:0]      peer_window,
    output logic             csum_rd_en,
    input  logic             csum_empty,
    input  logic [15:0]      csum_dout,
    input  logic             tx_user_tvalid,
    output logic             tx_user_tready,
    input  logic [63:0]      tx_user_tdata,
    input  logic [7:0]       tx_user_tkeep,
    output logic             desc_valid,
    input  logic             desc_ready,
    output logic [SEQ_W-1:0] desc_seq,
    output logic [15:0]      desc_csum,
    output logic [15:0]      desc_len,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic [31:0]      seg_count
);

    localparam int                 c_BEATS     = TCP_DATA_LENGTH / 8;
    localparam int                 c_CNT_W     = $clog2(c_BEATS + 1);
    localparam int                 c_CMP_W     = SEQ_W + 16;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);
    localparam logic [SEQ_W-1:0]   c_SEG_ADV   = SEQ_W'(TCP_DATA_LENGTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAP  = 2'd1,
        S_DESC = 2'd2,
        S_PAY  = 2'd3
    } state_t;

    state_t             r_state;
    logic [SEQ_W-1:0]   r_seq;
    logic [c_CNT_W-1:0] r_beat_cnt;
    logic [15:0]        r_csum;
    logic               r_desc_valid;
    logic               r_busy;

    logic [SEQ_W-1:0]   w_inflight;
    logic               w_win_ok;
    logic               w_start;
    logic               w_pay;
    logic               w_beat_xfer;
    logic               w_last_beat;
    logic               w_seg_done;

    // Modular distance keeps the window check correct across sequence wrap.
    assign w_inflight  = r_seq + c_SEG_ADV - ack_num;
    assign w_win_ok    = c_CMP_W'(w_inflight) <= c_CMP_W'(peer_window);

    assign w_start     = (r_state == S_IDLE) && !seq_load && enable &&
                         !csum_empty && w_win_ok;
    assign w_pay       = (r_state == S_PAY);
    assign w_beat_xfer = w_pay && tx_user_tvalid && m_axis_tready;
    assign w_last_beat = (r_beat_cnt == c_LAST_BEAT);
    assign w_seg_done  = w_beat_xfer && w_last_beat;

    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            r_state      <= S_IDLE;
            r_seq        <= '0;
            r_beat_cnt   <= '0;
            r_csum       <= '0;
            r_desc_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (seq_load) begin
                        r_seq <= init_seq;
                    end else if (w_start) begin
                        r_busy  <= 1'b1;
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    // FIFO data appears the cycle after the read strobe.
                    r_csum       <= csum_dout;
                    r_desc_valid <= 1'b1;
                    r_state      <= S_DESC;
                end
                S_DESC: begin
                    if (desc_ready) begin
                        r_desc_valid <= 1'b0;
                        r_beat_cnt   <= '0;
                        r_state      <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (w_beat_xfer) begin
                        if (w_last_beat) begin
                            r_seq      <= r_seq + c_SEG_ADV;
                            r_beat_cnt <= '0;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign csum_rd_en     = w_start;
    assign desc_valid     = r_desc_valid;
    assign desc_seq       = r_desc_valid ? r_seq  : '0;
    assign desc_csum      = r_desc_valid ? r_csum : '0;
    assign desc_len       = 16'(TCP_DATA_LENGTH);
    assign busy           = r_busy;

    // Payload is a pure pass-through, gated off entirely outside PAY.
    assign m_axis_tvalid  = w_pay && tx_user_tvalid;
    assign tx_user_tready = w_pay && m_axis_tready;
    assign m_axis_tdata   = w_pay ? tx_user_tdata : '0;
    assign m_axis_tkeep   = w_pay ? tx_user_tkeep : '0;
    assign m_axis_tlast   = w_pay && w_last_beat;

`ifdef SEG_STATS_EN
    logic [31:0] r_seg_count;

    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            r_seg_count <= '0;
        end else if (w_seg_done) begin
            r_seg_count <= r_seg_count + 32'd1;
        end
    end

    assign seg_count = r_seg_count;
`else
    logic w_unused_seg_done;
    assign w_unused_seg_done = w_seg_done;
    assign seg_count         = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_10g_ethernet_0_tx_seg_ctrl.sv
// ============================================================================
// Module   : tb_axi_10g_ethernet_0_tx_seg_ctrl
// Brief    : Self-checking bench for the TX segment scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi_10g_ethernet_0_tx_seg_ctrl;

    localparam int TDL   = 1456;
    localparam int BEATS = TDL / 8;

    logic        s_aclk = 1'b0;
    logic        s_areset = 1'b0;
    logic        enable, seq_load;
    logic [31:0] init_seq, ack_num;
    logic [15:0] peer_window;
    logic        csum_rd_en, csum_empty;
    logic [15:0] csum_dout;
    logic        tx_user_tvalid, tx_user_tready;
    logic [63:0] tx_user_tdata;
    logic [7:0]  tx_user_tkeep;
    logic        desc_valid, desc_ready;
    logic [31:0] desc_seq;
    logic [15:0] desc_csum, desc_len;
    logic        m_axis_tvalid, m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast, busy;
    logic [31:0] seg_count;

    axi_10g_ethernet_0_tx_seg_ctrl #(.TCP_DATA_LENGTH(TDL), .SEQ_W(32)) dut (
        .s_aclk(s_aclk), .s_areset(s_areset), .enable(enable), .seq_load(seq_load),
        .init_seq(init_seq), .ack_num(ack_num), .peer_window(peer_window),
        .csum_rd_en(csum_rd_en), .csum_empty(csum_empty), .csum_dout(csum_dout),
        .tx_user_tvalid(tx_user_tvalid), .tx_user_tready(tx_user_tready),
        .tx_user_tdata(tx_user_tdata), .tx_user_tkeep(tx_user_tkeep),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_seq(desc_seq),
        .desc_csum(desc_csum), .desc_len(desc_len),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .seg_count(seg_count)
    );

    always #5 s_aclk = ~s_aclk;

    typedef struct {
        logic [31:0] seq;
        logic [31:0] ack;
        logic [15:0] win;
        logic        en;
        logic        empty;
        logic        exp_rd;
    } win_vec_t;

    win_vec_t    tbl [12];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_seq;
    int          model_segs;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // One IDLE-state window/enable probe; inputs withdrawn before the edge.
    task automatic apply_win(input string nm, input logic [31:0] s, input logic [31:0] a,
                             input logic [15:0] w, input logic en, input logic emp,
                             input logic exp_rd);
        seq_load = 1'b1; init_seq = s; enable = 1'b1; csum_empty = 1'b0;
        ack_num = a; peer_window = w;
        @(negedge s_aclk);
        chk({nm, "_load_prio"}, csum_rd_en, 0);
        @(posedge s_aclk); #1;
        seq_load = 1'b0; enable = en; csum_empty = emp;
        @(negedge s_aclk);
        chk(nm, csum_rd_en, exp_rd);
        enable = 1'b0; csum_empty = 1'b1;
        @(posedge s_aclk); #1;
        @(negedge s_aclk);
        chk({nm, "_idle"}, busy, 0);
        @(posedge s_aclk); #1;
    endtask

    // Full segment against the model: checksum pop, descriptor, payload order.
    task automatic run_segment(input logic [15:0] cs, input int stall, input int abort_at,
                               input bit disturb, output int waited);
        logic [63:0] dq[$];
        logic [7:0]  kq[$];
        logic [31:0] sv_ack;
        logic [15:0] sv_win;
        int          idx, n;
        bit          got, done;
        for (int i = 0; i < BEATS; i++) begin
            dq.push_back({$urandom, $urandom});
            kq.push_back(8'($urandom));
        end
        sv_ack = ack_num; sv_win = peer_window;
        csum_empty = 1'b0;
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(negedge s_aclk);
            if (csum_rd_en === 1'b1) got = 1;
            else begin @(posedge s_aclk); #1; n++; end
        end
        waited = n;
        chk("csum_rd_en_seen", {63'd0, got}, 1);
        if (!got) begin csum_empty = 1'b1; return; end
        @(posedge s_aclk); #1;
        csum_empty = 1'b1; csum_dout = cs;
        @(negedge s_aclk);
        chk("cap_rd_en_single", csum_rd_en, 0);
        chk("cap_desc_low", desc_valid, 0);
        chk("cap_busy", busy, 1);
        @(posedge s_aclk); #1;
        csum_dout = 16'($urandom);
        done = 0; n = 0;
        while (!done && n < 50) begin
            desc_ready = ($urandom_range(0, 99) >= stall);
            if (disturb) begin seq_load = 1'b1; init_seq = $urandom; end
            @(negedge s_aclk);
            chk("desc_valid", desc_valid, 1);
            chk("desc_seq", desc_seq, model_seq);
            chk("desc_csum", desc_csum, cs);
            chk("desc_len", desc_len, TDL);
            done = desc_ready;
            @(posedge s_aclk); #1; n++;
        end
        desc_ready = 1'b0;
        idx = 0; n = 0;
        while (idx < BEATS && n < 4000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            tx_user_tvalid = ($urandom_range(0, 99) >= stall);
            m_axis_tready  = ($urandom_range(0, 99) >= stall);
            tx_user_tdata  = dq[idx];
            tx_user_tkeep  = kq[idx];
            if (disturb) begin
                enable = 1'b0; peer_window = 16'd0; ack_num = $urandom;
                seq_load = 1'b1; init_seq = $urandom;
            end
            @(negedge s_aclk);
            chk("pay_tvalid", m_axis_tvalid, tx_user_tvalid);
            chk("pay_tready", tx_user_tready, m_axis_tready);
            chk("pay_busy", busy, 1);
            if (tx_user_tvalid) begin
                chk("pay_tdata", m_axis_tdata, dq[idx]);
                chk("pay_tkeep", m_axis_tkeep, kq[idx]);
                chk("pay_tlast", m_axis_tlast, (idx == BEATS - 1));
            end
            if (tx_user_tvalid && m_axis_tready) idx++;
            @(posedge s_aclk); #1; n++;
        end
        if (abort_at >= 0) return;
        chk("pay_beat_count", idx, BEATS);
        seq_load = 1'b0;
        if (disturb) begin enable = 1'b1; ack_num = sv_ack; peer_window = sv_win; end
        tx_user_tvalid = 1'b1; m_axis_tready = 1'b1;
        @(negedge s_aclk);
        chk("post_busy", busy, 0);
        chk("post_m_tvalid", m_axis_tvalid, 0);
        chk("post_tx_tready", tx_user_tready, 0);
        chk("post_rd_en", csum_rd_en, 0);
        @(posedge s_aclk); #1;
        tx_user_tvalid = 1'b0; m_axis_tready = 1'b0;
        model_seq  = model_seq + 32'(TDL);
        model_segs = model_segs + 1;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_desc_valid"}, desc_valid, 0);
        chk({nm, "_desc_seq"}, desc_seq, 0);
        chk({nm, "_desc_csum"}, desc_csum, 0);
        chk({nm, "_desc_len"}, desc_len, TDL);
        chk({nm, "_m_tvalid"}, m_axis_tvalid, 0);
        chk({nm, "_m_tdata"}, m_axis_tdata, 0);
        chk({nm, "_m_tkeep"}, m_axis_tkeep, 0);
        chk({nm, "_m_tlast"}, m_axis_tlast, 0);
        chk({nm, "_tx_tready"}, tx_user_tready, 0);
        chk({nm, "_rd_en"}, csum_rd_en, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_seg_count"}, seg_count, 0);
    endtask

    task automatic check_seg_count(input string nm);
`ifdef SEG_STATS_EN
        chk(nm, seg_count, 32'(model_segs));
`else
        chk(nm, seg_count, 0);
`endif
    endtask

    initial begin
        int          w;
        logic [31:0] rs, ra, rd;
        logic [15:0] rw;

        tbl[0]  = '{32'h0000_1000, 32'h0000_1000, 16'hFFFF, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{32'h0000_1000, 32'h0000_1000, 16'd1000, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{32'h0000_1000, 32'h0000_1000, 16'd1456, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{32'h0000_1000, 32'h0000_1000, 16'd1455, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{32'h0000_1000, 32'h0000_1000, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{32'h0000_1000, 32'h0000_1000, 16'hFFFF, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{32'h0000_1000, 32'h0000_1000, 16'd0,    1'b1, 1'b0, 1'b0};
        tbl[7]  = '{32'hFFFF_FC00, 32'hFFFF_FC00, 16'd1456, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{32'hFFFF_FFF0, 32'h0000_0100, 16'd1184, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{32'hFFFF_FFF0, 32'h0000_0100, 16'd1183, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{32'h0000_1000, 32'h0000_2000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{32'h0000_5000, 32'h0000_1000, 16'hFFFF, 1'b1, 1'b0, 1'b1};

        enable = 0; seq_load = 0; init_seq = 0; ack_num = 0; peer_window = 0;
        csum_empty = 1; csum_dout = 0; tx_user_tvalid = 0; tx_user_tdata = 0;
        tx_user_tkeep = 0; desc_ready = 0; m_axis_tready = 0;
        model_seq = 0; model_segs = 0;

        #2 s_areset = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge s_aclk);
        #1 s_areset = 1'b0;

        for (int i = 0; i < 12; i++)
            apply_win($sformatf("win_vec%0d", i), tbl[i].seq, tbl[i].ack, tbl[i].win,
                      tbl[i].en, tbl[i].empty, tbl[i].exp_rd);

        for (int i = 0; i < 24; i++) begin
            rs = $urandom;
            case (i % 3)
                0:       ra = rs - 32'($urandom_range(0, 3000));
                1:       ra = rs + 32'($urandom_range(0, 3000));
                default: ra = $urandom;
            endcase
            rd = rs + 32'(TDL) - ra;
            rw = (i % 4 == 0) ? rd[15:0] : 16'($urandom_range(0, 65535));
            apply_win($sformatf("win_rand%0d", i), rs, ra, rw, 1'b1, 1'b0,
                      (rd <= {16'd0, rw}));
        end

        // Single segment, no stalls.
        seq_load = 1'b1; init_seq = 32'h0000_1000;
        @(posedge s_aclk); #1;
        seq_load = 1'b0; model_seq = 32'h0000_1000;
        ack_num = 32'h0000_1000; peer_window = 16'hFFFF; enable = 1'b1;
        run_segment(16'hBEEF, 0, -1, 1'b0, w);
        chk("first_start_latency", w, 0);

        // Closed window holds off, opening it starts next cycle; stalled payload.
        ack_num = model_seq; peer_window = 16'd1000; csum_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge s_aclk);
            chk("closed_win_rd_en", csum_rd_en, 0);
            chk("closed_win_busy", busy, 0);
            @(posedge s_aclk); #1;
        end
        peer_window = 16'd1456;
        run_segment(16'h1234, 50, -1, 1'b1, w);
        chk("open_win_start", w, 0);

        // Sequence wrap.
        seq_load = 1'b1; init_seq = 32'hFFFF_FC00;
        @(posedge s_aclk); #1;
        seq_load = 1'b0; model_seq = 32'hFFFF_FC00;
        ack_num = 32'hFFFF_FC00; peer_window = 16'hFFFF;
        run_segment(16'hA5A5, 30, -1, 1'b0, w);
        peer_window = 16'h0B5F; csum_empty = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge s_aclk);
            chk("wrap_win_closed", csum_rd_en, 0);
            @(posedge s_aclk); #1;
        end
        peer_window = 16'h0B60;
        run_segment(16'h5A5A, 30, -1, 1'b0, w);
        chk("wrap_win_open", w, 0);
        check_seg_count("seg_count_pre_reset");

        // Reset mid-payload.
        ack_num = model_seq; peer_window = 16'hFFFF;
        run_segment(16'h0F0F, 0, 50, 1'b0, w);
        tx_user_tvalid = 1'b1; m_axis_tready = 1'b1; csum_empty = 1'b1;
        s_areset = 1'b1;
        #1 check_all_zero("midseg_reset");
        @(posedge s_aclk); #1;
        s_areset = 1'b0; tx_user_tvalid = 1'b0; m_axis_tready = 1'b0;
        model_seq = 0; model_segs = 0; ack_num = 0; peer_window = 16'hFFFF;
        for (int i = 0; i < 3; i++) run_segment(16'(16'h1111 * (i + 1)), 25, -1, 1'b0, w);
        check_seg_count("seg_count_three");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
